// File: rtl/vt_syn_acc.sv
// vt_syn_acc: streaming weighted-digit accumulator producing a sum, its syndrome and a match flag per DNA word
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input beat handshake; in_data holds P 2-bit digits, digit j at [2j+1:2j]
//   in_last              final beat of a word
//   cfg_target           expected syndrome, sampled on the word-end beat
//   out_valid/out_ready  result handshake; result held stable while out_valid is high
//   out_sum              raw weighted sum of the word
//   out_syn              out_sum mod MOD
//   out_match            out_syn equals the sampled cfg_target
//   out_err              framing error (early in_last, or missing in_last on the final beat)
module vt_syn_acc #(
   parameter int N = 16,
   parameter int P = 4,
   parameter int MOD = 4 * N + 1,
   localparam int SW = $clog2(2 * N * (N + 1) + 1),
   localparam int MW = $clog2(MOD)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2*P-1:0] in_data,
   input  logic          in_last,
   input  logic [MW-1:0] cfg_target,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [SW-1:0] out_sum,
   output logic [MW-1:0] out_syn,
   output logic          out_match,
   output logic          out_err
);
   localparam int B = N / P;
   localparam int CW = (B > 1) ? $clog2(B) : 1;
   localparam int XW = (SW > MW) ? SW : MW;

   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, idx;
   logic [SW-1:0] sum_q, sum_d, contrib;
   logic [SW-1:0] out_sum_q;
   logic [MW-1:0] out_syn_q;
   logic          out_match_q, out_err_q;
   logic          acc, last_beat, word_end;
   logic [XW-1:0] syn_x;

   // A beat taken outside ACC (IDLE or back-to-back from HOLD) is always beat 0 of a new word
   assign idx       = (state_q == ACC) ? cnt_q : '0;
   assign last_beat = idx == CW'(B - 1);
   assign word_end  = in_last || last_beat;
   assign acc       = in_valid && in_ready;

   always_comb begin
      contrib = '0;
      for (int j = 0; j < P; j++)
         contrib = contrib + SW'(in_data[2*j +: 2] == 2'b00 ? 3'd4 : {1'b0, in_data[2*j +: 2]})
                           * (SW'(idx) * SW'(P) + SW'(j + 1));
   end

   assign sum_d = acc ? ((state_q == ACC ? sum_q : '0) + contrib) : sum_q;
   assign cnt_d = acc ? (word_end ? '0 : idx + 1'b1) : cnt_q;
   assign syn_x = XW'(sum_d) % XW'(MOD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         sum_q <= '0;
         out_sum_q <= '0;
         out_syn_q <= '0;
         out_match_q <= 1'b0;
         out_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         sum_q <= sum_d;
         if (acc && word_end) begin
            out_sum_q <= sum_d;
            out_syn_q <= syn_x[MW-1:0];
            out_match_q <= syn_x[MW-1:0] == cfg_target;
            out_err_q <= in_last ^ last_beat;
         end
      end
   end

   // Any accepted beat follows the same word-end rule; otherwise HOLD drains on out_ready
   always_comb
      state_d = acc ? (word_end ? HOLD : ACC)
              : (state_q == HOLD && out_ready) ? IDLE : state_q;

   always_comb begin
      in_ready  = (state_q != HOLD) || out_ready;
      out_valid = state_q == HOLD;
      out_sum   = out_valid ? out_sum_q : '0;
      out_syn   = out_valid ? out_syn_q : '0;
      out_match = out_valid && out_match_q;
      out_err   = out_valid && out_err_q;
   end
endmodule

// File: tb/tb_vt_syn_acc.sv
// tb_vt_syn_acc: directed and randomized check of vt_syn_acc against a digit-level reference model
module tb_vt_syn_acc;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_data = '0;
   logic       in_last = 1'b0;
   logic [4:0] cfg_target = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [5:0] out_sum;
   logic [4:0] out_syn;
   logic       out_match;
   logic       out_err;

   int vectors = 0;
   int miscompares = 0;
   int mpos = 0;
   int msum = 0;

   vt_syn_acc #(.N(4), .P(2), .MOD(17)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .cfg_target(cfg_target),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_syn(out_syn), .out_match(out_match), .out_err(out_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Model: digit at word position i = 2*beat + j has value (00->4, else code) and weight i+1
   task automatic push(input logic [3:0] d, input logic l, input int tgt);
      int s, pos, n, v;
      logic e, er, r;
      pos = mpos;
      s = (pos == 0) ? 0 : msum;
      for (int j = 0; j < 2; j++) begin
         v = (d >> (2 * j)) & 3;
         if (v == 0) v = 4;
         s += v * (pos * 2 + j + 1);
      end
      e = l || pos == 1;
      er = l != (pos == 1);
      in_valid = 1'b1;
      in_data = d;
      in_last = l;
      cfg_target = (tgt < 0) ? 5'(s % 17) : 5'(tgt);
      n = 0;
      forever begin
         #1 r = in_ready;
         @(posedge clk);
         #1;
         if (r) break;
         out_ready = 1'b1;
         n++;
         if (n > 20) break;
      end
      in_valid = 1'b0;
      chk("accepted", 32'(r), 1);
      if (r) begin
         msum = s;
         mpos = e ? 0 : pos + 1;
         chk("out_valid", 32'(out_valid), 32'(e));
         if (e) begin
            chk("out_sum", 32'(out_sum), s);
            chk("out_syn", 32'(out_syn), s % 17);
            chk("out_match", 32'(out_match), 32'((s % 17) == int'(cfg_target)));
            chk("out_err", 32'(out_err), 32'(er));
         end
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_ready", 32'(in_ready), 1);
      chk("rst_sum", 32'(out_sum), 0);
      chk("rst_syn", 32'(out_syn), 0);
      chk("rst_match", 32'(out_match), 0);
      chk("rst_err", 32'(out_err), 0);

      push(4'b0000, 1'b0, 0);
      push(4'b0000, 1'b1, 0);
      chk("req41_sum", 32'(out_sum), 40);
      chk("req41_syn", 32'(out_syn), 6);

      push(4'b1001, 1'b0, 13);
      push(4'b0011, 1'b1, 13);
      chk("req42_sum", 32'(out_sum), 30);
      chk("req42_match", 32'(out_match), 1);
      push(4'b1001, 1'b0, 12);
      push(4'b0011, 1'b1, 12);
      chk("req42_nomatch", 32'(out_match), 0);

      push(4'b1001, 1'b1, 5);
      chk("req43_sum", 32'(out_sum), 5);
      chk("req43_err", 32'(out_err), 1);
      push(4'b0110, 1'b0, -1);
      push(4'b1100, 1'b1, -1);

      push(4'b0101, 1'b0, -1);
      push(4'b1111, 1'b0, -1);
      chk("req44_err", 32'(out_err), 1);
      push(4'b0010, 1'b1, -1);
      push(4'b0010, 1'b0, -1);
      push(4'b1000, 1'b1, -1);

      push(4'b0111, 1'b0, -1);
      out_ready = 1'b0;
      push(4'b1110, 1'b1, -1);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("hold_valid", 32'(out_valid), 1);
         chk("hold_sum", 32'(out_sum), msum);
         chk("hold_syn", 32'(out_syn), msum % 17);
         chk("hold_ready", 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      #1 chk("b2b_ready", 32'(in_ready), 1);
      push(4'b0001, 1'b0, -1);
      push(4'b0100, 1'b1, -1);

      push(4'b1011, 1'b0, -1);
      rst = 1'b1;
      #2;
      chk("midrst_valid", 32'(out_valid), 0);
      chk("midrst_sum", 32'(out_sum), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      mpos = 0;
      msum = 0;
      repeat (2) begin
         @(posedge clk);
         #1 chk("postrst_valid", 32'(out_valid), 0);
      end
      push(4'b0110, 1'b0, -1);
      push(4'b0011, 1'b1, -1);

      for (int k = 0; k < 80; k++) begin
         out_ready = $urandom_range(0, 3) != 0;
         push(4'($urandom), $urandom_range(0, 2) == 0,
              $urandom_range(0, 1) ? -1 : int'($urandom_range(0, 16)));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/vt_syn_acc.md
VT_SYN_ACC -- requirements
Module: vt_syn_acc

Interface
REQ-001 Parameter N, default 16: digits per DNA word, 2 bits per digit; N >= 2.
REQ-002 Parameter P, default 4: digits per input beat; N SHALL be a multiple of P; beats per word B = N/P.
REQ-003 Parameter MOD, default 4*N+1: syndrome modulus; MOD >= 2.
REQ-004 Derived SW = clog2(2*N*(N+1)+1) and MW = clog2(MOD): widths of the raw sum and the syndrome.
REQ-005 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 in_valid  in  1  input beat valid.
REQ-008 in_ready  out  1  block can accept a beat.
REQ-009 in_data  in  2P  digit j of the beat is in_data[2j+1:2j]; the first beat of a word carries digits 0..P-1.
REQ-010 in_last  in  1  marks the final beat of a word.
REQ-011 cfg_target  in  MW  expected syndrome; sampled on the final beat.
REQ-012 out_valid  out  1  result valid.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 out_sum  out  SW  raw weighted sum.
REQ-015 out_syn  out  MW  out_sum mod MOD.
REQ-016 out_match  out  1  out_syn == sampled cfg_target.
REQ-017 out_err  out  1  framing error on this word.

Function
REQ-018 A beat SHALL be accepted only in a cycle where in_valid && in_ready.
REQ-019 Digit at word position i = b*P + j (b = beat index, from 0) SHALL use weight i+1.
REQ-020 Digit value: 2'b01->1, 2'b10->2, 2'b11->3, 2'b00->4.
REQ-021 The sum SHALL add value*weight over all accepted digits of the word, with no truncation within SW.
REQ-022 The FSM SHALL have three states: IDLE, ACC and HOLD.
REQ-023 IDLE: a beat is accepted; the sum is loaded with the beat's contribution; the FSM goes to ACC.
REQ-024 Exception to REQ-023: if the word ends on that beat, the FSM goes directly to HOLD.
REQ-025 ACC: each accepted beat adds its contribution and increments the beat counter.
REQ-026 In ACC, the word end moves the FSM to HOLD.
REQ-027 Word end is an accepted beat with in_last=1, or the B-th accepted beat, whichever comes first.
REQ-028 out_err=1 if in_last arrives on beat k < B-1, or if beat B-1 arrives with in_last=0.
REQ-029 When out_err=1, the result SHALL still cover only the beats received.
REQ-030 After the B-th beat arrives without in_last, the next beat SHALL start a new word.
REQ-031 Latency: out_valid SHALL rise on the clock edge that accepts the word-end beat, i.e. it is visible the next cycle.
REQ-032 While out_valid=1, out_sum, out_syn, out_match and out_err SHALL be held stable.
REQ-033 HOLD SHALL be left on out_valid && out_ready.
REQ-034 in_ready SHALL be 1 in IDLE and ACC.
REQ-035 In HOLD, in_ready SHALL equal out_ready, so a new first beat can be accepted in the same cycle the result is consumed (back-to-back).
REQ-036 A back-to-back beat (REQ-035) SHALL follow the IDLE rules of REQ-023/REQ-024.
REQ-037 B=1 (P=N): every accepted beat is a whole word; out_err=1 only if in_last=0.
REQ-038 in_ready SHALL be a function of state and out_ready only; it SHALL NOT depend on in_valid.

Reset
REQ-039 rst SHALL force IDLE, clear the beat counter and the accumulator, and drive all outputs to 0, except in_ready, which SHALL be 1 after reset deassertion.
REQ-040 rst asserted mid-word or in HOLD SHALL discard the partial or pending result; no out_valid follows.

Verification (N=4, P=2, MOD=17)
REQ-041 Beats 4'b0000, 4'b0000 (last) -> out_sum=40, out_syn=6, out_err=0, out_valid one cycle after the last beat.
REQ-042 Beats 4'b1001, 4'b0011 (last), cfg_target=13 -> out_sum=30, out_syn=13, out_match=1; with cfg_target=12 -> out_match=0.
REQ-043 Beat 4'b1001 with in_last=1 -> out_sum=5, out_syn=5, out_err=1; the following beat starts a new word.
REQ-044 Two beats with in_last=0 -> result issued after beat 2 with out_err=1; the third beat begins a new word.
REQ-045 out_ready held low 3 cycles -> outputs stable and in_ready=0; then out_ready=1 with a new first beat present -> that beat is accepted in the same cycle.
REQ-046 rst pulsed after the first beat -> out_valid stays 0; the next full word computes correctly from zero.
